// File: rtl/usb_crc_checker_if.sv
// Receive-side bit stream and result bus for usb_crc_checker.
// Optional macro USB_CRC_ERRCNT_EN adds the err_count result.
interface usb_crc_checker_if #(
   parameter int CNT_BITS = 11
);
   logic                start;
   logic                mode;
   logic                bit_valid;
   logic                bit_in;
   logic                eop;
   logic                busy;
   logic                done;
   logic                crc_ok;
   logic                crc_err;
   logic                len_err;
   logic [CNT_BITS-1:0] bit_cnt;
`ifdef USB_CRC_ERRCNT_EN
   logic [7:0]          err_count;

   modport master (output start, mode, bit_valid, bit_in, eop,
                   input  busy, done, crc_ok, crc_err, len_err, bit_cnt, err_count);
   modport slave  (input  start, mode, bit_valid, bit_in, eop,
                   output busy, done, crc_ok, crc_err, len_err, bit_cnt, err_count);
`else
   modport master (output start, mode, bit_valid, bit_in, eop,
                   input  busy, done, crc_ok, crc_err, len_err, bit_cnt);
   modport slave  (input  start, mode, bit_valid, bit_in, eop,
                   output busy, done, crc_ok, crc_err, len_err, bit_cnt);
`endif
endinterface

// File: rtl/usb_crc_checker.sv
// Serial USB receive CRC checker (CRC5 tokens / CRC16 data), LSB-first bits.
// Result (pass/fail, length fault, bit count) appears one cycle after eop.
// Optional macro USB_CRC_ERRCNT_EN adds a saturating 8-bit error counter.
module usb_crc_checker #(
   parameter int          CNT_BITS = 11,
   parameter logic [4:0]  POLY5    = 5'h05,
   parameter logic [15:0] POLY16   = 16'h8005,
   parameter logic [4:0]  RES5     = 5'h0C,
   parameter logic [15:0] RES16    = 16'h800D
) (
   input logic                clk,
   input logic                rst,
   usb_crc_checker_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

   localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
   localparam logic [CNT_BITS-1:0] MIN5    = CNT_BITS'(6);
   localparam logic [CNT_BITS-1:0] MIN16   = CNT_BITS'(17);

   state_e              state_q, state_d;
   logic                mode_q, mode_d;
   logic [15:0]         rem_q, rem_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic                ok_q, ok_d;
   logic                err_q, err_d;
   logic                len_q, len_d;

   logic [15:0]         rem_sh, rem_n;
   logic [CNT_BITS-1:0] cnt_n;
   logic                fb, len_n, ok_n;

   // One LFSR step for the latched width; CRC5 keeps the upper 11 bits at zero.
   always_comb begin
      fb     = 1'b0;
      rem_sh = '0;
      if (mode_q) begin
         fb     = bus.bit_in ^ rem_q[15];
         rem_sh = {rem_q[14:0], 1'b0} ^ (fb ? POLY16 : 16'h0000);
      end else begin
         fb     = bus.bit_in ^ rem_q[4];
         rem_sh = {11'b0, ({rem_q[3:0], 1'b0} ^ (fb ? POLY5 : 5'h00))};
      end
   end

   // Remainder/count including this cycle's bit, and the verdict if eop closes now.
   always_comb begin
      rem_n = bus.bit_valid ? rem_sh : rem_q;
      cnt_n = cnt_q;
      if (bus.bit_valid && (cnt_q != CNT_MAX))
         cnt_n = cnt_q + 1'b1;
      len_n = (cnt_n < (mode_q ? MIN16 : MIN5)) || (cnt_n == CNT_MAX);
      ok_n  = (mode_q ? (rem_n == RES16) : (rem_n[4:0] == RES5)) && !len_n;
   end

   // Next-state logic; start always wins, including over eop in ACCUM.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      ok_d    = ok_q;
      err_d   = err_q;
      len_d   = len_q;
      case (state_q)
         IDLE, ACCUM: begin
            if (bus.start) begin
               state_d = ACCUM;
               mode_d  = bus.mode;
               rem_d   = bus.mode ? 16'hFFFF : 16'h001F;
               cnt_d   = '0;
               ok_d    = 1'b0;
               err_d   = 1'b0;
               len_d   = 1'b0;
            end else if (state_q == ACCUM) begin
               rem_d = rem_n;
               cnt_d = cnt_n;
               if (bus.eop) begin
                  state_d = DONE;
                  len_d   = len_n;
                  ok_d    = ok_n;
                  err_d   = !ok_n;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= 1'b0;
         rem_q   <= 16'hFFFF;
         cnt_q   <= '0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
         len_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
         len_q   <= len_d;
      end
   end

   assign bus.busy    = (state_q == ACCUM);
   assign bus.done    = (state_q == DONE);
   assign bus.crc_ok  = ok_q;
   assign bus.crc_err = err_q;
   assign bus.len_err = len_q;
   assign bus.bit_cnt = cnt_q;

`ifdef USB_CRC_ERRCNT_EN
   logic [7:0] errcnt_q, errcnt_d;

   // Count failed packets on the done cycle, sticking at 8'hFF.
   always_comb begin
      errcnt_d = errcnt_q;
      if ((state_q == DONE) && err_q && (errcnt_q != 8'hFF))
         errcnt_d = errcnt_q + 8'd1;
   end

   // Error counter register; cleared only by rst.
   always_ff @(posedge clk) begin
      if (rst) errcnt_q <= 8'h00;
      else     errcnt_q <= errcnt_d;
   end

   assign bus.err_count = errcnt_q;
`endif

endmodule
